// File: rtl/serial_sub_pkg.sv
// Shared types and elaboration helpers for the digit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Digit counter width: $clog2 of the digit count, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_legal(input int unsigned width, input int unsigned digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit ripple of full-subtractor cells.
module sub_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             bin_i,
  output logic [DIGIT-1:0] d_o,
  output logic             bout_o
);

  always_comb begin
    logic brw;
    brw = bin_i;
    d_o = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      d_o[i] = a_i[i] ^ b_i[i] ^ brw;
      brw    = (~a_i[i] & (b_i[i] | brw)) | (b_i[i] & brw);
    end
    bout_o = brw;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial a - b - bin behind valid/ready, LSB digit first.
// Define SERIAL_SUB_SAT_EN to saturate negative results to zero.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] difference,
  output logic             borrow,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!params_legal(WIDTH, DIGIT)) begin : g_illegal
    $error("serial_subtractor: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q, dout_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, bout_q, zero_q, ovalid_q, iready_q;

  logic [DIGIT-1:0] dig_d;
  logic             dbr_d;
  logic [WIDTH-1:0] diff_d, res_d;
  logic             zero_d;

  sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
    .a_i    (a_q[DIGIT-1:0]),
    .b_i    (b_q[DIGIT-1:0]),
    .bin_i  (br_q),
    .d_o    (dig_d),
    .bout_o (dbr_d)
  );

  // New digit enters at the top so the result is LSB-aligned after N shifts.
  always_comb begin
    diff_d = (diff_q >> DIGIT) | (WIDTH'(dig_d) << (WIDTH - DIGIT));
`ifdef SERIAL_SUB_SAT_EN
    res_d  = dbr_d ? '0 : diff_d;
`else
    res_d  = diff_d;
`endif
    zero_d = (res_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovalid_q <= 1'b0;
      iready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            br_q     <= bin;
            cnt_q    <= '0;
            iready_q <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_q    <= a_q >> DIGIT;
          b_q    <= b_q >> DIGIT;
          br_q   <= dbr_d;
          diff_q <= diff_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            dout_q   <= res_d;
            bout_q   <= dbr_d;
            zero_q   <= zero_d;
            ovalid_q <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            dout_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovalid_q <= 1'b0;
            iready_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = iready_q;
  assign out_valid  = ovalid_q;
  assign difference = dout_q;
  assign borrow     = bout_q;
  assign zero       = zero_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle subtractor that computes `a - b - bin` over WIDTH-bit unsigned operands, DIGIT bits per clock, LSB digit first, with a registered borrow chained between digits. It is the sequential successor of the single-bit half subtractor cell. It sits behind a valid/ready handshake so arithmetic units and testbenches can stream operand pairs through it. It trades latency for a narrow datapath: one DIGIT-wide subtract cell reused WIDTH/DIGIT times.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly. Elaboration error otherwise.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- difference  output  WIDTH  result.
- borrow  output  1  borrow-out of the MSB digit (1 ⇔ a < b + bin).
- zero  output  1  difference == 0, as presented on the output.

## Operation
- N = WIDTH/DIGIT. States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, latch a, b into shift registers, load the borrow register with bin, clear the digit counter, and go to RUN.
- RUN: each cycle, subtract the low digit of a, b and the borrow register. Shift the DIGIT-bit result into the top of the difference register. Update the borrow register and increment the counter. After the N-th digit, go to DONE. in_ready=0 and in_valid is ignored.
- DONE: out_valid=1. difference, borrow and zero are stable while out_ready=0. On out_ready, go to IDLE.
- No bypass: a new operand pair is never accepted in the same cycle as a result handshake.
- Arithmetic: difference = (a - b - bin) mod 2^WIDTH; borrow = 1 iff a < b + bin (unsigned, WIDTH+1-bit compare).
- Reset, including during RUN or DONE: immediately go to IDLE and abandon the in-flight operation. All outputs go to reset values: in_ready=1 is the only output high; out_valid, difference, borrow all 0; zero=0 (held low whenever out_valid=0).
- out_ready while out_valid=0 has no effect.

## Timing
- Acceptance edge E0. The RUN digits occupy edges E1..EN. out_valid rises after EN, so it is first visible N cycles after E0.
- Latencies: 8 cycles at WIDTH=8/DIGIT=1; 2 cycles at DIGIT=4.
- Result handshake edge Ed. in_ready=1 in the cycle after Ed. Minimum issue interval is N+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SERIAL_SUB_SAT_EN defined: unsigned saturation. If the final borrow=1, difference is forced to 0 and zero=1; borrow still reports 1.
- SERIAL_SUB_SAT_EN undefined: difference wraps modulo 2^WIDTH. zero reflects the wrapped value.

## Structure
- Package serial_sub_pkg: state enum typedef (IDLE/RUN/DONE), a function for counter width ($clog2 of N, minimum 1), and the DIGIT/WIDTH legality check.
- Sub-module sub_digit: combinational, DIGIT-bit ripple of full-subtractor cells with borrow-in/borrow-out. Instantiated once inside serial_subtractor.
- Top holds the FSM, operand shift registers, borrow register, counter and output registers.

## Test plan
All scenarios at WIDTH=8, DIGIT=1 unless stated.
- a=0x5A, b=0x23, bin=0 -> difference=0x37, borrow=0, zero=0; out_valid exactly 8 cycles after acceptance.
- a=0x10, b=0x20, bin=0 -> difference=0xF0, borrow=1. With SERIAL_SUB_SAT_EN: difference=0x00, zero=1.
- a=0x00, b=0x00, bin=1 -> difference=0xFF, borrow=1. a=0x42, b=0x42, bin=0 -> difference=0x00, borrow=0, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs unchanged and in_ready=0 throughout. in_valid held high is not accepted until the cycle after the handshake.
- Reset: assert rst_n=0 at cycle 4 of RUN -> out_valid, difference, borrow, zero all 0 asynchronously; in_ready=1. The next operation after release yields the correct result.
- WIDTH=16, DIGIT=4: a=0x1234, b=0x0FFF, bin=0 -> difference=0x0235, borrow=0, latency 4 cycles. Random 1000-pair sweep matches the (a-b-bin) model.
